watch_alarm_control: RTL and testbench

Parametrised successor to the watch `control` block. It keeps time (hh:mm:ss) from a clock prescaler and supports set and alarm-edit modes. It holds `ALARM_NUM` independent alarms, each with its own enable, a bounded ring duration and an optional snooze. It sits between the button/switch debouncers and the display driver/buzzer.

---
 rtl/watch_alarm_control.sv | 271 +++++++++++++++++++++++++++
 tb/tb_watch_alarm_control.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/watch_alarm_control.sv
// watch_alarm_control
//   Time-of-day keeper (hh:mm:ss) with set mode, alarm-edit mode and
//   ALARM_NUM independent alarms, each with its own enable and a bounded
//   ring duration. Optional snooze support is built when WATCH_SNOOZE_EN
//   is defined; without it the snooze input is ignored.
//
// Ports
//   clock        system clock, rising edge
//   reset        asynchronous active-low reset
//   set          level, selects SET mode (priority over alerm)
//   alerm        level, selects ALARM_EDIT mode
//   alerm_sel    alarm edited/displayed in ALARM_EDIT mode
//   alerm_switch per-alarm enable
//   minute_set   level, increments minute field while held
//   hour_set     level, increments hour field while held
//   snooze       snooze request, rising-edge sensitive
//   time_data    {hh, mm, ss} display data, 8 bits per field, binary
//   alerm_equal  buzzer drive, OR of alerm_active
//   alerm_active per-alarm ringing flags
//   mode         0 = RUN, 1 = SET, 2 = ALARM_EDIT
module watch_alarm_control #(
  parameter int unsigned SECOND_CNT = 50000000,
  parameter int unsigned ALARM_NUM  = 4,
  parameter int unsigned SEL_W      = 2,
  parameter int unsigned SET_DIV    = 1,
  parameter int unsigned RING_SEC   = 60,
  parameter int unsigned SNOOZE_MIN = 5
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 set,
  input  logic                 alerm,
  input  logic [SEL_W-1:0]     alerm_sel,
  input  logic [ALARM_NUM-1:0] alerm_switch,
  input  logic                 minute_set,
  input  logic                 hour_set,
  input  logic                 snooze,
  output logic [23:0]          time_data,
  output logic                 alerm_equal,
  output logic [ALARM_NUM-1:0] alerm_active,
  output logic [1:0]           mode
);

  localparam int unsigned PW = $clog2(SECOND_CNT);
  localparam int unsigned DW = (SET_DIV > 1) ? $clog2(SET_DIV) : 1;
  localparam int unsigned RW = $clog2(RING_SEC + 1);

  typedef enum logic [1:0] {
    MODE_RUN  = 2'd0,
    MODE_SET  = 2'd1,
    MODE_EDIT = 2'd2
  } mode_e;

  function automatic logic [5:0] inc60(input logic [5:0] v);
    return (v == 6'd59) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [4:0] inc24(input logic [4:0] v);
    return (v == 5'd23) ? 5'd0 : v + 5'd1;
  endfunction

  mode_e                        mode_q, mode_d;
  logic [PW-1:0]                pre_q, pre_d;
  logic                         tick, new_min;
  logic                         m_stb, h_stb;
  logic [DW-1:0]                mdiv_q, mdiv_d, hdiv_q, hdiv_d;
  logic [4:0]                   hh_q, hh_d;
  logic [5:0]                   mm_q, mm_d, ss_q, ss_d;
  logic [ALARM_NUM-1:0][4:0]    al_hh_q, al_hh_d;
  logic [ALARM_NUM-1:0][5:0]    al_mm_q, al_mm_d;
  logic [ALARM_NUM-1:0][RW-1:0] ring_q, ring_d;
  logic [ALARM_NUM-1:0]         act_q, act_d;
  logic                         eq_q;
  logic [23:0]                  disp_q, disp_d;
  logic                         sel_hit;
  logic [4:0]                   sel_hh;
  logic [5:0]                   sel_mm;
  logic                         snz_clr;
  logic [ALARM_NUM-1:0]         snz_ring;

  // Mode decode, prescaler, set strobes and time-of-day update.
  always_comb begin
    mode_d = MODE_RUN;
    if (set) begin
      mode_d = MODE_SET;
    end else if (alerm) begin
      mode_d = MODE_EDIT;
    end

    tick    = (mode_q != MODE_SET) && (pre_q == PW'(SECOND_CNT - 1));
    new_min = tick && (ss_q == 6'd59);

    if ((mode_q == MODE_SET) || tick) begin
      pre_d = '0;
    end else begin
      pre_d = pre_q + PW'(1);
    end

    // Strobe on the first held cycle, then every SET_DIV cycles.
    m_stb = minute_set && (mdiv_q == '0);
    h_stb = hour_set && (hdiv_q == '0);
    if (!minute_set || (mdiv_q == DW'(SET_DIV - 1))) begin
      mdiv_d = '0;
    end else begin
      mdiv_d = mdiv_q + DW'(1);
    end
    if (!hour_set || (hdiv_q == DW'(SET_DIV - 1))) begin
      hdiv_d = '0;
    end else begin
      hdiv_d = hdiv_q + DW'(1);
    end

    hh_d = hh_q;
    mm_d = mm_q;
    ss_d = ss_q;
    if (mode_q == MODE_SET) begin
      if (m_stb) mm_d = inc60(mm_q);
      if (h_stb) hh_d = inc24(hh_q);
      if (mode_d != MODE_SET) ss_d = '0;
    end else if (tick) begin
      ss_d = inc60(ss_q);
      if (ss_q == 6'd59) begin
        mm_d = inc60(mm_q);
        if (mm_q == 6'd59) hh_d = inc24(hh_q);
      end
    end
  end

  // Alarm editing and display selection. Out-of-range selects match no
  // alarm, so edits are dropped and the display reads zero.
  always_comb begin
    al_hh_d = al_hh_q;
    al_mm_d = al_mm_q;
    sel_hit = 1'b0;
    sel_hh  = '0;
    sel_mm  = '0;
    for (int unsigned i = 0; i < ALARM_NUM; i++) begin
      if (alerm_sel == SEL_W'(i)) begin
        if (mode_q == MODE_EDIT) begin
          if (m_stb) al_mm_d[i] = inc60(al_mm_q[i]);
          if (h_stb) al_hh_d[i] = inc24(al_hh_q[i]);
        end
        sel_hit = 1'b1;
        sel_hh  = al_hh_d[i];
        sel_mm  = al_mm_d[i];
      end
    end

    if (mode_d == MODE_EDIT) begin
      disp_d = sel_hit ? {3'b000, sel_hh, 2'b00, sel_mm, 8'd0} : '0;
    end else begin
      disp_d = {3'b000, hh_d, 2'b00, mm_d, 2'b00, ss_d};
    end
  end

  // Ring control: start beats decrement, disable and snooze beat start.
  always_comb begin
    act_d  = act_q;
    ring_d = ring_q;
    for (int unsigned i = 0; i < ALARM_NUM; i++) begin
      if (tick && act_q[i]) begin
        ring_d[i] = ring_q[i] - RW'(1);
        if (ring_q[i] == RW'(1)) act_d[i] = 1'b0;
      end
      if (alerm_switch[i] &&
          ((new_min && (al_hh_q[i] == hh_d) && (al_mm_q[i] == mm_d)) ||
           snz_ring[i])) begin
        act_d[i]  = 1'b1;
        ring_d[i] = RW'(RING_SEC);
      end
      if (!alerm_switch[i] || snz_clr) act_d[i] = 1'b0;
    end
  end

`ifdef WATCH_SNOOZE_EN
  logic                 snz_prev_q;
  logic                 snz_arm_q, snz_arm_d;
  logic [4:0]           snz_hh_q, snz_hh_d;
  logic [5:0]           snz_mm_q, snz_mm_d;
  logic [ALARM_NUM-1:0] snz_mask_q, snz_mask_d;
  logic [6:0]           mm_sum;

  always_comb begin
    snz_clr    = snooze && !snz_prev_q && (|act_q);
    mm_sum     = {1'b0, mm_q} + 7'(SNOOZE_MIN);
    snz_arm_d  = snz_arm_q;
    snz_hh_d   = snz_hh_q;
    snz_mm_d   = snz_mm_q;
    snz_mask_d = snz_mask_q;
    snz_ring   = '0;

    if (snz_arm_q && new_min && (hh_d == snz_hh_q) && (mm_d == snz_mm_q)) begin
      snz_ring  = snz_mask_q;
      snz_arm_d = 1'b0;
    end
    // Target is taken from the current time; minute overflow carries into
    // the hour, which itself wraps at midnight.
    if (snz_clr) begin
      snz_arm_d  = 1'b1;
      snz_mask_d = act_q;
      if (mm_sum >= 7'd60) begin
        snz_mm_d = 6'(mm_sum - 7'd60);
        snz_hh_d = inc24(hh_q);
      end else begin
        snz_mm_d = mm_sum[5:0];
        snz_hh_d = hh_q;
      end
    end
    if (mode_q == MODE_SET) snz_arm_d = 1'b0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      snz_prev_q <= 1'b0;
      snz_arm_q  <= 1'b0;
      snz_hh_q   <= '0;
      snz_mm_q   <= '0;
      snz_mask_q <= '0;
    end else begin
      snz_prev_q <= snooze;
      snz_arm_q  <= snz_arm_d;
      snz_hh_q   <= snz_hh_d;
      snz_mm_q   <= snz_mm_d;
      snz_mask_q <= snz_mask_d;
    end
  end
`else
  logic unused_snooze;
  assign unused_snooze = snooze;
  assign snz_clr       = 1'b0;
  assign snz_ring      = '0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mode_q  <= MODE_RUN;
      pre_q   <= '0;
      mdiv_q  <= '0;
      hdiv_q  <= '0;
      hh_q    <= '0;
      mm_q    <= '0;
      ss_q    <= '0;
      al_hh_q <= '0;
      al_mm_q <= '0;
      ring_q  <= '0;
      act_q   <= '0;
      eq_q    <= 1'b0;
      disp_q  <= '0;
    end else begin
      mode_q  <= mode_d;
      pre_q   <= pre_d;
      mdiv_q  <= mdiv_d;
      hdiv_q  <= hdiv_d;
      hh_q    <= hh_d;
      mm_q    <= mm_d;
      ss_q    <= ss_d;
      al_hh_q <= al_hh_d;
      al_mm_q <= al_mm_d;
      ring_q  <= ring_d;
      act_q   <= act_d;
      eq_q    <= |act_d;
      disp_q  <= disp_d;
    end
  end

  assign time_data    = disp_q;
  assign alerm_equal  = eq_q;
  assign alerm_active = act_q;
  assign mode         = mode_q;

endmodule

// File: tb/tb_watch_alarm_control.sv
module tb_watch_alarm_control;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        set = 1'b0;
  logic        alerm = 1'b0;
  logic [1:0]  alerm_sel = '0;
  logic [3:0]  alerm_switch = '0;
  logic [2:0]  sw3 = '0;
  logic        minute_set = 1'b0;
  logic        hour_set = 1'b0;
  logic        snooze = 1'b0;
  logic [23:0] time_data, td3;
  logic        alerm_equal, eq3;
  logic [3:0]  alerm_active;
  logic [2:0]  act3;
  logic [1:0]  mode, mode3;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  watch_alarm_control #(
    .SECOND_CNT(4), .ALARM_NUM(4), .SEL_W(2), .SET_DIV(1),
    .RING_SEC(60), .SNOOZE_MIN(5)
  ) u_dut (
    .clock(clk), .reset(reset), .set(set), .alerm(alerm),
    .alerm_sel(alerm_sel), .alerm_switch(alerm_switch),
    .minute_set(minute_set), .hour_set(hour_set), .snooze(snooze),
    .time_data(time_data), .alerm_equal(alerm_equal),
    .alerm_active(alerm_active), .mode(mode)
  );

  watch_alarm_control #(
    .SECOND_CNT(4), .ALARM_NUM(3), .SEL_W(2), .SET_DIV(1),
    .RING_SEC(60), .SNOOZE_MIN(5)
  ) u_dut3 (
    .clock(clk), .reset(reset), .set(set), .alerm(alerm),
    .alerm_sel(alerm_sel), .alerm_switch(sw3),
    .minute_set(minute_set), .hour_set(hour_set), .snooze(snooze),
    .time_data(td3), .alerm_equal(eq3),
    .alerm_active(act3), .mode(mode3)
  );

  function automatic logic [23:0] tm(input int h, input int m, input int s);
    return {8'(h), 8'(m), 8'(s)};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_time(input string tag, input logic [23:0] target, input int budget);
    int n;
    n = 0;
    while (time_data !== target && n < budget) begin
      cyc(1);
      n++;
    end
    check(tag, 32'(time_data), 32'(target));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // Reset state, SET requested already so it takes effect on release.
    set = 1'b1;
    cyc(2);
    check("rst_time", 32'(time_data), 32'h0);
    check("rst_active", 32'(alerm_active), 32'h0);
    check("rst_equal", 32'(alerm_equal), 32'h0);
    check("rst_mode", 32'(mode), 32'h0);
    check("rst_time3", 32'(td3), 32'h0);
    check("rst_active3", 32'(act3), 32'h0);
    check("rst_mode3", 32'(mode3), 32'h0);
    check("rst_equal3", 32'(eq3), 32'h0);
    reset = 1'b1;
    cyc(1);
    check("mode_set", 32'(mode), 32'h1);

    // Rollover: set 23:59, then 60 ticks to midnight.
    hour_set = 1'b1;
    cyc(23);
    hour_set = 1'b0;
    check("set_hour", 32'(time_data), 32'(tm(23, 0, 0)));
    minute_set = 1'b1;
    cyc(59);
    minute_set = 1'b0;
    check("set_min", 32'(time_data), 32'(tm(23, 59, 0)));
    set = 1'b0;
    cyc(1);
    check("mode_run", 32'(mode), 32'h0);
    check("exit_set", 32'(time_data), 32'(tm(23, 59, 0)));
    cyc(4);
    check("tick1", 32'(time_data), 32'(tm(23, 59, 1)));
    cyc(4 * 58);
    check("ss59", 32'(time_data), 32'(tm(23, 59, 59)));
    cyc(4);
    check("midnight", 32'(time_data), 32'(tm(0, 0, 0)));

    // Alarm 0 at 00:06, time set to 00:05:00.
    alerm_switch = 4'b0001;
    alerm = 1'b1;
    alerm_sel = 2'd0;
    cyc(1);
    check("mode_edit", 32'(mode), 32'h2);
    minute_set = 1'b1;
    cyc(6);
    minute_set = 1'b0;
    check("edit_a0", 32'(time_data), 32'(tm(0, 6, 0)));
    alerm = 1'b0;
    set = 1'b1;
    cyc(1);
    minute_set = 1'b1;
    cyc(5);
    minute_set = 1'b0;
    check("set_hhmm", 32'(time_data[23:8]), 32'h0005);
    set = 1'b0;
    cyc(1);
    check("time_0500", 32'(time_data), 32'(tm(0, 5, 0)));
    wait_time("reach_0559", tm(0, 5, 59), 300);
    check("pre_ring", 32'(alerm_active), 32'h0);
    cyc(4);
    check("ring_time", 32'(time_data), 32'(tm(0, 6, 0)));
    check("ring_act", 32'(alerm_active), 32'h1);
    check("ring_eq", 32'(alerm_equal), 32'h1);
    wait_time("reach_0659", tm(0, 6, 59), 300);
    check("ring_last", 32'(alerm_active), 32'h1);
    cyc(4);
    check("ring_end_time", 32'(time_data), 32'(tm(0, 7, 0)));
    check("ring_end_act", 32'(alerm_active), 32'h0);

    // Alarms 1 and 2 both at 00:08.
    alerm = 1'b1;
    alerm_sel = 2'd1;
    cyc(1);
    minute_set = 1'b1;
    cyc(8);
    minute_set = 1'b0;
    check("edit_a1", 32'(time_data), 32'(tm(0, 8, 0)));
    alerm_sel = 2'd2;
    cyc(1);
    minute_set = 1'b1;
    cyc(8);
    minute_set = 1'b0;
    check("edit_a2", 32'(time_data), 32'(tm(0, 8, 0)));
    alerm = 1'b0;
    alerm_switch = 4'b0111;
    wait_time("reach_0759", tm(0, 7, 59), 300);
    check("multi_pre", 32'(alerm_active), 32'h0);
    cyc(4);
    check("multi_time", 32'(time_data), 32'(tm(0, 8, 0)));
    check("multi_act", 32'(alerm_active), 32'h6);
    alerm_switch = 4'b0101;
    cyc(1);
    check("sw_drop_act", 32'(alerm_active), 32'h4);
    check("sw_drop_eq", 32'(alerm_equal), 32'h1);

    snooze = 1'b1;
    cyc(1);
`ifdef WATCH_SNOOZE_EN
    check("snz_act", 32'(alerm_active), 32'h0);
    check("snz_eq", 32'(alerm_equal), 32'h0);
    snooze = 1'b0;
    wait_time("snz_target", tm(0, 13, 0), 1400);
    check("snz_rering", 32'(alerm_active), 32'h4);
`else
    check("snz_ignored", 32'(alerm_active), 32'h4);
    snooze = 1'b0;
`endif

    // Editing a ringing alarm keeps it ringing.
    alerm = 1'b1;
    alerm_sel = 2'd2;
    cyc(1);
    minute_set = 1'b1;
    cyc(1);
    minute_set = 1'b0;
    check("edit_ringing", 32'(time_data), 32'(tm(0, 9, 0)));
    check("edit_keep_act", 32'(alerm_active), 32'h4);
    alerm_sel = 2'd3;
    cyc(1);
    minute_set = 1'b1;
    cyc(7);
    minute_set = 1'b0;
    check("edit_a3", 32'(time_data), 32'(tm(0, 7, 0)));
    check("edit_oob3", 32'(td3), 32'h0);
    check("edit_mode", 32'(mode), 32'h2);
    alerm = 1'b0;
    cyc(1);
    check("still_ring", 32'(alerm_active), 32'h4);

    // Asynchronous reset mid-ring.
    #3;
    reset = 1'b0;
    #1;
    check("arst_time", 32'(time_data), 32'h0);
    check("arst_act", 32'(alerm_active), 32'h0);
    check("arst_eq", 32'(alerm_equal), 32'h0);
    check("arst_mode", 32'(mode), 32'h0);
    alerm_switch = 4'b0000;
    @(posedge clk);
    #1;
    reset = 1'b1;
    cyc(3);
    check("post_rst0", 32'(time_data), 32'(tm(0, 0, 0)));
    cyc(1);
    check("post_rst1", 32'(time_data), 32'(tm(0, 0, 1)));
    check("post_rst_act", 32'(alerm_active), 32'h0);
    check("dut3_quiet", 32'(act3), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
